// File: rtl/g711_dec_arbiter.sv
// Round-robin arbiter sharing one combinational G711 expander among NCH channels.
// Results return with their channel tag over a valid/ready port.
module g711_dec_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic [8*NCH-1:0] pcm_in,
  input  logic [NCH-1:0]   law_in,
  output logic [NCH-1:0]   ack,
  output logic             dec_law,
  output logic [7:0]       dec_pcm,
  input  logic [13:0]      dec_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_chan,
  output logic [13:0]      out_mag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    OUTPUT
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  ptr, ptr_n;
  logic [CW-1:0]  gnt, idx;
  logic           hit;
  logic [NCH-1:0] ack_n;
  logic           dec_law_n;
  logic [7:0]     dec_pcm_n;
  logic           out_valid_n;
  logic [CW-1:0]  out_chan_n;
  logic [13:0]    out_mag_n;

  // first requester after ptr, wrapping modulo NCH
  always_comb begin
    hit = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CW'((int'(ptr) + i) % NCH);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    ack_n       = '0;
    dec_law_n   = dec_law;
    dec_pcm_n   = dec_pcm;
    out_valid_n = out_valid;
    out_chan_n  = out_chan;
    out_mag_n   = out_mag;
    unique case (state)
      IDLE: begin
        if (hit) begin
          dec_pcm_n  = pcm_in[{gnt, 3'b000} +: 8];
          dec_law_n  = law_in[gnt];
          out_chan_n = gnt;
          ptr_n      = gnt;
          ack_n[gnt] = 1'b1;
          state_n    = DECODE;
        end
      end
      DECODE: begin
        // dec_pcm/dec_law settled one cycle ago, so dec_mag is valid here
        out_mag_n   = dec_mag;
        out_valid_n = 1'b1;
        state_n     = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= CW'(NCH - 1);
      ack       <= '0;
      dec_law   <= 1'b0;
      dec_pcm   <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_mag   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      ack       <= ack_n;
      dec_law   <= dec_law_n;
      dec_pcm   <= dec_pcm_n;
      out_valid <= out_valid_n;
      out_chan  <= out_chan_n;
      out_mag   <= out_mag_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_g711_dec_arbiter.sv
// Bench for g711_dec_arbiter with a behavioural G711 expander on dec_*.
// Expected results are queued at drive time and popped on each handshake.
module tb_g711_dec_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] pcm_in;
  logic [3:0]  law_in;
  logic [3:0]  ack;
  logic        dec_law;
  logic [7:0]  dec_pcm;
  logic [13:0] dec_mag;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;
  logic [13:0] out_mag;
  logic        busy;

  always #5 clk = ~clk;

  function automatic logic [13:0] expand(input logic law,
                                         input logic [7:0] pcm);
    logic [7:0] c;
    int e, m, v;
    if (!law) begin
      c = ~pcm;
      e = int'(c[6:4]);
      m = int'(c[3:0]);
      v = ((2 * m + 33) << e) - 33;
      return {c[7], 13'(v)};
    end
    c = pcm ^ 8'h55;
    e = int'(c[6:4]);
    m = int'(c[3:0]);
    v = (e == 0) ? (2 * m + 1) : ((2 * m + 33) << (e - 1));
    return {1'b0, ~c[7], 12'(v)};
  endfunction

  assign dec_mag = expand(dec_law, dec_pcm);

  g711_dec_arbiter #(.NCH(4), .CW(2)) dut (
    .clk(clk), .reset(reset), .req(req),
    .pcm_in(pcm_in), .law_in(law_in), .ack(ack),
    .dec_law(dec_law), .dec_pcm(dec_pcm), .dec_mag(dec_mag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_mag(out_mag), .busy(busy)
  );

  typedef struct {
    logic [1:0]  chan;
    logic [13:0] mag;
    int          cyc;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } ack_t;

  ev_t  exp_q[$];
  ev_t  out_q[$];
  ack_t ack_q[$];
  ev_t  o_ev;
  ack_t a_ev;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   multi_ack = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ack != 4'b0) begin
      a_ev.cyc = cyc;
      a_ev.vec = ack;
      ack_q.push_back(a_ev);
      if ($countones(ack) != 1) multi_ack++;
    end
    if (out_valid && out_ready) begin
      o_ev.chan = out_chan;
      o_ev.mag  = out_mag;
      o_ev.cyc  = cyc;
      out_q.push_back(o_ev);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic law, input logic [7:0] pcm);
    pcm_in[8*k +: 8] = pcm;
    law_in[k] = law;
  endtask

  task automatic push_exp(input int k);
    ev_t e;
    e.chan = 2'(k);
    e.mag  = expand(law_in[k], pcm_in[8*k +: 8]);
    e.cyc  = 0;
    exp_q.push_back(e);
  endtask

  task automatic clear_q();
    ack_q.delete();
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_ack(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (ack_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_out(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (out_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    ev_t o, e;
    reset = 1'b1;
    req = 4'b0;
    pcm_in = '0;
    law_in = '0;
    out_ready = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({ack, dec_law, dec_pcm, out_valid, out_chan, out_mag, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: ack=%b pcm=%h valid=%b chan=%0d mag=%h busy=%b required all 0",
               ack, dec_pcm, out_valid, out_chan, out_mag, busy);
    end
    reset = 1'b0;
    tick();
    set_ch(0, 1'b0, 8'h12);
    set_ch(1, 1'b1, 8'h34);
    req = 4'b0001;
    tick();
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if ({ack, dec_law, dec_pcm, out_valid, out_chan, out_mag, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_decode: ack=%b pcm=%h valid=%b chan=%0d mag=%h busy=%b required all 0",
               ack, dec_pcm, out_valid, out_chan, out_mag, busy);
    end
    req = 4'b0011;
    tick();
    tick();
    reset = 1'b0;
    n_chk++;
    if (ack_q.size() != 0 || out_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_dropped: acks=%0d outs=%0d required 0 and 0",
               ack_q.size(), out_q.size());
    end
    clear_q();
    push_exp(0);
    wait_ack(1, 10, ok);
    req = 4'b0;
    n_chk++;
    if (!ok || ack_q[0].vec !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: ack=%b required 0001",
               ok ? ack_q[0].vec : 4'b0);
      return;
    end
    wait_out(1, 10, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_out_timeout: outs=0 required 1");
      return;
    end
    o = out_q.pop_front();
    e = exp_q.pop_front();
    n_chk++;
    if (o.chan !== e.chan || o.mag !== e.mag) begin
      n_fail++;
      $display("FAIL reset_out: chan=%0d mag=%h required chan=%0d mag=%h",
               o.chan, o.mag, e.chan, e.mag);
    end
  endtask

  task automatic test_decode();
    logic        lw[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  pc[4]  = '{8'hFF, 8'h00, 8'hD5, 8'h55};
    logic [13:0] mg[4]  = '{14'h0000, 14'h3F5F, 14'h0001, 14'h1001};
    bit ok;
    ev_t o, e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_q();
      set_ch(i, lw[i], pc[i]);
      e.chan = 2'(i);
      e.mag  = mg[i];
      e.cyc  = 0;
      exp_q.push_back(e);
      req = 4'(1 << i);
      wait_ack(1, 10, ok);
      req = 4'b0;
      n_chk++;
      if (!ok || ack_q[0].vec !== 4'(1 << i)) begin
        n_fail++;
        $display("FAIL decode_ack%0d: ack=%b required %b",
                 i, ok ? ack_q[0].vec : 4'b0, 4'(1 << i));
        continue;
      end
      wait_out(1, 10, ok);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL decode_timeout%0d: outs=0 required 1", i);
        continue;
      end
      o = out_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.chan !== e.chan || o.mag !== e.mag) begin
        n_fail++;
        $display("FAIL decode_out%0d: chan=%0d mag=%h required chan=%0d mag=%h",
                 i, o.chan, o.mag, e.chan, e.mag);
      end
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    bit ok;
    ev_t o, e;
    tick();
    clear_q();
    for (int k = 0; k < 4; k++)
      set_ch(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) push_exp(order[i]);
    out_ready = 1'b1;
    req = 4'hF;
    wait_ack(5, 40, ok);
    req = 4'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_timeout: acks=%0d required 5", ack_q.size());
      return;
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (ack_q[i].vec !== 4'(1 << order[i])) begin
        n_fail++;
        $display("FAIL rr_ack%0d: ack=%b required %b",
                 i, ack_q[i].vec, 4'(1 << order[i]));
      end
      if (i > 0) begin
        n_chk++;
        if (ack_q[i].cyc - ack_q[i-1].cyc != 3) begin
          n_fail++;
          $display("FAIL rr_gap%0d: gap=%0d required 3",
                   i, ack_q[i].cyc - ack_q[i-1].cyc);
        end
      end
    end
    wait_out(5, 20, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_out_timeout: outs=%0d required 5", out_q.size());
      return;
    end
    for (int i = 0; i < 5; i++) begin
      o = out_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.chan !== e.chan || o.mag !== e.mag) begin
        n_fail++;
        $display("FAIL rr_out%0d: chan=%0d mag=%h required chan=%0d mag=%h",
                 i, o.chan, o.mag, e.chan, e.mag);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    ev_t o, e;
    tick();
    clear_q();
    set_ch(1, 1'b0, 8'($urandom_range(0, 255)));
    set_ch(2, 1'b1, 8'($urandom_range(0, 255)));
    push_exp(1);
    push_exp(2);
    out_ready = 1'b0;
    req = 4'b0110;
    wait_ack(1, 10, ok);
    req = 4'b0100;
    n_chk++;
    if (!ok || ack_q[0].vec !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_ack: ack=%b required 0010", ok ? ack_q[0].vec : 4'b0);
      req = 4'b0;
      out_ready = 1'b1;
      return;
    end
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_chan !== exp_q[0].chan ||
          out_mag !== exp_q[0].mag || ack !== 4'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b chan=%0d mag=%h ack=%b required 1 %0d %h 0000",
                 i, out_valid, out_chan, out_mag, ack, exp_q[0].chan, exp_q[0].mag);
      end
      tick();
    end
    n_chk++;
    if (ack_q.size() != 1) begin
      n_fail++;
      $display("FAIL bp_stall_ack: acks=%0d required 1", ack_q.size());
    end
    out_ready = 1'b1;
    wait_ack(2, 10, ok);
    req = 4'b0;
    n_chk++;
    if (!ok || out_q.size() < 1 || ack_q[1].vec !== 4'b0100 ||
        ack_q[1].cyc - out_q[0].cyc != 2) begin
      n_fail++;
      $display("FAIL bp_next_grant: ack=%b delta=%0d required 0100 2",
               ok ? ack_q[1].vec : 4'b0,
               (ok && out_q.size() > 0) ? ack_q[1].cyc - out_q[0].cyc : -1);
      return;
    end
    wait_out(2, 10, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_out_timeout: outs=%0d required 2", out_q.size());
      return;
    end
    for (int i = 0; i < 2; i++) begin
      o = out_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.chan !== e.chan || o.mag !== e.mag) begin
        n_fail++;
        $display("FAIL bp_out%0d: chan=%0d mag=%h required chan=%0d mag=%h",
                 i, o.chan, o.mag, e.chan, e.mag);
      end
    end
  endtask

  task automatic test_withdraw();
    bit ok;
    ev_t o, e;
    tick();
    clear_q();
    set_ch(1, 1'b1, 8'($urandom_range(0, 255)));
    set_ch(2, 1'b0, 8'($urandom_range(0, 255)));
    set_ch(3, 1'b0, 8'($urandom_range(0, 255)));
    push_exp(1);
    push_exp(3);
    out_ready = 1'b0;
    req = 4'b0010;
    wait_ack(1, 10, ok);
    req = 4'b0100;
    tick();
    req = 4'b1000;
    tick();
    out_ready = 1'b1;
    wait_ack(2, 10, ok);
    req = 4'b0;
    n_chk++;
    if (!ok || ack_q[0].vec !== 4'b0010 || ack_q[1].vec !== 4'b1000) begin
      n_fail++;
      $display("FAIL wd_order: acks=%0d second=%b required 2 and 1000",
               ack_q.size(), ack_q.size() > 1 ? ack_q[1].vec : 4'b0);
      return;
    end
    wait_out(2, 10, ok);
    repeat (6) tick();
    n_chk++;
    if (!ok || ack_q.size() != 2 || out_q.size() != 2) begin
      n_fail++;
      $display("FAIL wd_count: acks=%0d outs=%0d required 2 and 2",
               ack_q.size(), out_q.size());
      return;
    end
    for (int i = 0; i < 2; i++) begin
      o = out_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.chan !== e.chan || o.mag !== e.mag) begin
        n_fail++;
        $display("FAIL wd_out%0d: chan=%0d mag=%h required chan=%0d mag=%h",
                 i, o.chan, o.mag, e.chan, e.mag);
      end
    end
  endtask

  task automatic test_lone();
    bit ok;
    int idle;
    ev_t o, e;
    tick();
    clear_q();
    set_ch(3, 1'b1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) push_exp(3);
    out_ready = 1'b1;
    req = 4'b1000;
    idle = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ack_q.size() >= 4) begin
        ok = 1'b1;
        break;
      end
      if (ack_q.size() >= 1 && !busy) idle++;
      tick();
    end
    req = 4'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL lone_timeout: acks=%0d required 4", ack_q.size());
      return;
    end
    n_chk++;
    if (idle != 3) begin
      n_fail++;
      $display("FAIL lone_idle: idle_cycles=%0d required 3", idle);
    end
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (ack_q[i].vec !== 4'b1000 || ack_q[i].cyc - ack_q[i-1].cyc != 3) begin
        n_fail++;
        $display("FAIL lone_ack%0d: ack=%b gap=%0d required 1000 3",
                 i, ack_q[i].vec, ack_q[i].cyc - ack_q[i-1].cyc);
      end
    end
    wait_out(4, 10, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL lone_out_timeout: outs=%0d required 4", out_q.size());
      return;
    end
    for (int i = 0; i < 4; i++) begin
      o = out_q.pop_front();
      e = exp_q.pop_front();
      n_chk++;
      if (o.chan !== e.chan || o.mag !== e.mag) begin
        n_fail++;
        $display("FAIL lone_out%0d: chan=%0d mag=%h required chan=%0d mag=%h",
                 i, o.chan, o.mag, e.chan, e.mag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_lone();
    n_chk++;
    if (multi_ack != 0) begin
      n_fail++;
      $display("FAIL ack_onehot: multi_ack_cycles=%0d required 0", multi_ack);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
